// File: rtl/mac_block_seq_if.sv
// Valid/ready operand stream that feeds the MAC block sequencer.
// The producer drives data/valid through master; the sequencer answers with ready through slave.
interface mac_block_seq_if #(
    parameter int dataWidth = 4
);
    logic [dataWidth-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/mac_block_seq.sv
// Sequencer for one MAC tile: loads operands into the tile memory and then streams a
// dot product through the tile's registered multiplier into its accumulator.
module mac_block_seq #(
    parameter int elementsNum = 4,
    parameter int dataWidth   = 4,
    localparam int AW         = $clog2(elementsNum)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_load,
    input  logic                 start_compute,
    mac_block_seq_if.slave       s_if,
    output logic [dataWidth-1:0] blk_in,
    output logic                 blk_we_mem,
    output logic [AW-1:0]        blk_wraddr,
    output logic [AW-1:0]        blk_rdaddr,
    output logic                 blk_zero_in,
    output logic                 blk_we_out,
    output logic                 busy,
    output logic                 load_done,
    output logic                 result_valid
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [AW-1:0] CNT_LAST = AW'(elementsNum - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          p_vld_q, p_vld_d;
    logic          p_first_q, p_first_d;
    logic          load_done_q, load_done_d;
    logic          result_valid_q, result_valid_d;
    logic          accept;

    assign s_if.in_ready = (state_q == LOAD) || (state_q == COMPUTE);
    assign accept        = s_if.in_valid && s_if.in_ready;

    assign blk_in       = s_if.in_data;
    assign blk_we_mem   = (state_q == LOAD) && s_if.in_valid;
    assign blk_wraddr   = (state_q == LOAD) ? cnt_q : '0;
    assign blk_rdaddr   = (state_q == COMPUTE) ? cnt_q : '0;
    // The tile's product register lags the read by one cycle, so the accumulator
    // controls follow the registered beat flags rather than the live handshake.
    assign blk_we_out   = p_vld_q;
    assign blk_zero_in  = p_vld_q && p_first_q;
    assign busy         = (state_q != IDLE);
    assign load_done    = load_done_q;
    assign result_valid = result_valid_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        p_vld_d        = 1'b0;
        p_first_d      = p_first_q;
        load_done_d    = 1'b0;
        result_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_load) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else if (start_compute) begin
                    state_d = COMPUTE;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        load_done_d = 1'b1;
                    end
                end
            end
            COMPUTE: begin
                if (accept) begin
                    cnt_d     = cnt_q + AW'(1);
                    p_vld_d   = 1'b1;
                    p_first_d = (cnt_q == '0);
                    if (cnt_q == CNT_LAST) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            DRAIN: begin
                state_d        = DONE;
                result_valid_d = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            p_vld_q        <= 1'b0;
            p_first_q      <= 1'b0;
            load_done_q    <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            p_vld_q        <= p_vld_d;
            p_first_q      <= p_first_d;
            load_done_q    <= load_done_d;
            result_valid_q <= result_valid_d;
        end
    end

endmodule

// File: tb/tb_mac_block_seq.sv
// Bench for mac_block_seq: cycle tables for the documented sequences plus randomized
// load/compute runs checked against a dot product of the loaded and streamed vectors.
module tb_mac_block_seq;
    localparam int N    = 4;
    localparam int DW   = 4;
    localparam int AW   = 2;
    localparam int ACCW = 2 * DW + AW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_load;
    logic          start_compute;
    logic [DW-1:0] blk_in;
    logic          blk_we_mem;
    logic [AW-1:0] blk_wraddr;
    logic [AW-1:0] blk_rdaddr;
    logic          blk_zero_in;
    logic          blk_we_out;
    logic          busy;
    logic          load_done;
    logic          result_valid;

    mac_block_seq_if #(.dataWidth(DW)) s_if ();

    mac_block_seq #(.elementsNum(N), .dataWidth(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_load   (start_load),
        .start_compute(start_compute),
        .s_if         (s_if.slave),
        .blk_in       (blk_in),
        .blk_we_mem   (blk_we_mem),
        .blk_wraddr   (blk_wraddr),
        .blk_rdaddr   (blk_rdaddr),
        .blk_zero_in  (blk_zero_in),
        .blk_we_out   (blk_we_out),
        .busy         (busy),
        .load_done    (load_done),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    // Tile model: combinational memory read, unconditional product register, gated accumulator.
    logic [DW-1:0]   t_mem [N];
    logic [2*DW-1:0] t_prod;
    logic [ACCW-1:0] t_acc;
    always @(posedge clk) begin
        if (blk_we_mem) t_mem[blk_wraddr] <= blk_in;
        t_prod <= (2*DW)'(t_mem[blk_rdaddr]) * (2*DW)'(blk_in);
        if (blk_we_out) t_acc <= (blk_zero_in ? '0 : t_acc) + ACCW'(t_prod);
    end

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] ref_mem [N];

    typedef struct {
        logic          sl;
        logic          sc;
        logic          iv;
        logic [DW-1:0] d;
        logic [10:0]   exp;
    } vec_t;

    function automatic vec_t mk(input int sl, input int sc, input int iv, input int d,
                                input int rdy, input int wem, input int wa, input int ra,
                                input int z, input int weo, input int bsy, input int ld,
                                input int rv);
        vec_t v;
        v.sl  = 1'(sl);
        v.sc  = 1'(sc);
        v.iv  = 1'(iv);
        v.d   = DW'(d);
        v.exp = {1'(rdy), 1'(wem), 2'(wa), 2'(ra), 1'(z), 1'(weo), 1'(bsy), 1'(ld), 1'(rv)};
        return v;
    endfunction

    function automatic logic [10:0] outs();
        return {s_if.in_ready, blk_we_mem, blk_wraddr, blk_rdaddr, blk_zero_in,
                blk_we_out, busy, load_done, result_valid};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input string tag, input int k);
        start_load    = v.sl;
        start_compute = v.sc;
        s_if.in_valid = v.iv;
        s_if.in_data  = v.d;
        @(negedge clk);
        chk($sformatf("%s cyc%0d {rdy,wem,wa,ra,z,weo,busy,ld,rv}", tag, k),
            32'(outs()), 32'(v.exp));
        tick();
    endtask

    task automatic run_load(input logic [DW-1:0] v [N], input int stall_pct, input string tag);
        int   i;
        int   cyc;
        logic go;
        i = 0;
        cyc = 0;
        start_load    = 1'b1;
        s_if.in_valid = 1'b0;
        tick();
        start_load = 1'b0;
        while (i < N && cyc < 200) begin
            go = ($urandom_range(99) >= 32'(stall_pct));
            s_if.in_valid = go;
            s_if.in_data  = go ? v[i] : DW'($urandom);
            @(negedge clk);
            chk({tag, " load ready"}, 32'(s_if.in_ready), 32'd1);
            chk({tag, " load we_mem"}, 32'(blk_we_mem), 32'(go));
            if (go) chk({tag, " load wraddr"}, 32'(blk_wraddr), 32'(i));
            tick();
            if (go) begin
                ref_mem[i] = v[i];
                i++;
            end
            cyc++;
        end
        s_if.in_valid = 1'b0;
        if (i < N) chk({tag, " load beats before timeout"}, 32'(i), 32'(N));
        @(negedge clk);
        chk({tag, " load_done pulse"}, 32'(load_done), 32'd1);
        chk({tag, " busy after load"}, 32'(busy), 32'd0);
        tick();
        @(negedge clk);
        chk({tag, " load_done one cycle"}, 32'(load_done), 32'd0);
        tick();
    endtask

    // poke >= 1 pulses start_load in that cycle of the compute, which must be ignored.
    task automatic run_compute(input logic [DW-1:0] v [N], input int stall_pct, input int poke,
                               input string tag);
        int   i, lat, stalls, weo_cnt, z_cnt, wem_cnt;
        bit   seen;
        logic go;
        logic [ACCW-1:0] exp_dot;
        exp_dot = '0;
        for (int k = 0; k < N; k++) exp_dot += ACCW'(ref_mem[k]) * ACCW'(v[k]);
        i = 0; stalls = 0; weo_cnt = 0; z_cnt = 0; wem_cnt = 0; seen = 0;
        start_compute = 1'b1;
        s_if.in_valid = 1'b0;
        tick();
        start_compute = 1'b0;
        lat = 1;
        while (lat < 300) begin
            go = 1'b0;
            if (i < N) go = ($urandom_range(99) >= 32'(stall_pct));
            s_if.in_valid = go;
            s_if.in_data  = go ? v[i] : DW'($urandom);
            start_load    = (lat == poke);
            @(negedge clk);
            if (i < N) begin
                chk({tag, " compute ready"}, 32'(s_if.in_ready), 32'd1);
                chk({tag, " compute rdaddr"}, 32'(blk_rdaddr), 32'(i));
            end
            weo_cnt += int'(blk_we_out);
            z_cnt   += int'(blk_zero_in);
            wem_cnt += int'(blk_we_mem);
            if (result_valid) begin
                seen = 1;
                break;
            end
            tick();
            if (i < N) begin
                if (go) i++;
                else stalls++;
            end
            lat++;
        end
        start_load    = 1'b0;
        s_if.in_valid = 1'b0;
        chk({tag, " result_valid seen"}, 32'(seen), 32'd1);
        chk({tag, " result latency"}, 32'(lat), 32'(N + 2 + stalls));
        chk({tag, " tile acc"}, 32'(t_acc), 32'(exp_dot));
        chk({tag, " we_out count"}, 32'(weo_cnt), 32'(N));
        chk({tag, " zero_in count"}, 32'(z_cnt), 32'd1);
        chk({tag, " no mem writes"}, 32'(wem_cnt), 32'd0);
        tick();
        @(negedge clk);
        chk({tag, " idle after done"}, 32'({busy, result_valid}), 32'd0);
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t ld_tab [7];
        vec_t cp_tab [8];
        vec_t st_tab [10];
        vec_t bo_tab [7];
        logic [DW-1:0] va [N];
        logic [DW-1:0] vb [N];

        ld_tab[0] = mk(1,0,0,0,  0,0,0,0,0,0,0,0,0);
        ld_tab[1] = mk(0,0,1,1,  1,1,0,0,0,0,1,0,0);
        ld_tab[2] = mk(0,0,1,2,  1,1,1,0,0,0,1,0,0);
        ld_tab[3] = mk(0,0,1,3,  1,1,2,0,0,0,1,0,0);
        ld_tab[4] = mk(0,0,1,4,  1,1,3,0,0,0,1,0,0);
        ld_tab[5] = mk(0,0,0,0,  0,0,0,0,0,0,0,1,0);
        ld_tab[6] = mk(0,0,0,0,  0,0,0,0,0,0,0,0,0);

        cp_tab[0] = mk(0,1,0,0,  0,0,0,0,0,0,0,0,0);
        cp_tab[1] = mk(0,0,1,4,  1,0,0,0,0,0,1,0,0);
        cp_tab[2] = mk(0,0,1,3,  1,0,0,1,1,1,1,0,0);
        cp_tab[3] = mk(0,0,1,2,  1,0,0,2,0,1,1,0,0);
        cp_tab[4] = mk(0,0,1,1,  1,0,0,3,0,1,1,0,0);
        cp_tab[5] = mk(0,0,0,0,  0,0,0,0,0,1,1,0,0);
        cp_tab[6] = mk(0,0,0,0,  0,0,0,0,0,0,1,0,1);
        cp_tab[7] = mk(0,0,0,0,  0,0,0,0,0,0,0,0,0);

        st_tab[0] = mk(0,1,0,0,  0,0,0,0,0,0,0,0,0);
        st_tab[1] = mk(0,0,1,4,  1,0,0,0,0,0,1,0,0);
        st_tab[2] = mk(0,0,0,15, 1,0,0,1,1,1,1,0,0);
        st_tab[3] = mk(0,0,0,15, 1,0,0,1,0,0,1,0,0);
        st_tab[4] = mk(0,0,1,3,  1,0,0,1,0,0,1,0,0);
        st_tab[5] = mk(0,0,1,2,  1,0,0,2,0,1,1,0,0);
        st_tab[6] = mk(0,0,1,1,  1,0,0,3,0,1,1,0,0);
        st_tab[7] = mk(0,0,0,0,  0,0,0,0,0,1,1,0,0);
        st_tab[8] = mk(0,0,0,0,  0,0,0,0,0,0,1,0,1);
        st_tab[9] = mk(0,0,0,0,  0,0,0,0,0,0,0,0,0);

        bo_tab[0] = mk(1,1,0,0,  0,0,0,0,0,0,0,0,0);
        bo_tab[1] = mk(0,0,1,2,  1,1,0,0,0,0,1,0,0);
        bo_tab[2] = mk(0,0,1,2,  1,1,1,0,0,0,1,0,0);
        bo_tab[3] = mk(0,0,1,2,  1,1,2,0,0,0,1,0,0);
        bo_tab[4] = mk(0,0,1,2,  1,1,3,0,0,0,1,0,0);
        bo_tab[5] = mk(0,0,0,0,  0,0,0,0,0,0,0,1,0);
        bo_tab[6] = mk(0,0,0,0,  0,0,0,0,0,0,0,0,0);

        rst = 1'b1;
        start_load = 1'b0;
        start_compute = 1'b0;
        s_if.in_valid = 1'b0;
        s_if.in_data = 4'h9;
        tick();
        tick();
        @(negedge clk);
        chk("reset outputs", 32'(outs()), 32'd0);
        chk("blk_in copy", 32'(blk_in), 32'h9);
        rst = 1'b0;
        tick();

        foreach (ld_tab[k]) apply(ld_tab[k], "load1234", k);
        for (int k = 0; k < N; k++) ref_mem[k] = DW'(k + 1);
        foreach (cp_tab[k]) apply(cp_tab[k], "compute4321", k);
        chk("compute4321 acc", 32'(t_acc), 32'd20);
        foreach (st_tab[k]) apply(st_tab[k], "stalled", k);
        chk("stalled acc", 32'(t_acc), 32'd20);

        foreach (bo_tab[k]) apply(bo_tab[k], "both_starts", k);
        for (int k = 0; k < N; k++) ref_mem[k] = 4'd2;
        va = '{4'd3, 4'd1, 4'd4, 4'd1};
        run_compute(va, 0, 2, "poke_load");
        chk("poke_load acc", 32'(t_acc), 32'd18);

        // Reset in cycle 3 of a compute aborts it without a result pulse.
        start_compute = 1'b1;
        tick();
        start_compute = 1'b0;
        s_if.in_valid = 1'b1;
        s_if.in_data = 4'd5;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_if.in_valid = 1'b0;
        @(negedge clk);
        chk("abort outputs", 32'(outs()), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            chk($sformatf("abort quiet cyc%0d", k), 32'({busy, result_valid}), 32'd0);
        end
        tick();
        va = '{4'd7, 4'd0, 4'd9, 4'd11};
        run_compute(va, 0, 0, "after_abort");

        va = '{4'd15, 4'd15, 4'd15, 4'd15};
        run_load(va, 0, "all15");
        run_compute(va, 30, 0, "all15");
        chk("all15 acc", 32'(t_acc), 32'd900);

        for (int r = 0; r < 15; r++) begin
            for (int k = 0; k < N; k++) begin
                va[k] = DW'($urandom);
                vb[k] = DW'($urandom);
            end
            run_load(va, 40, $sformatf("rnd%0d", r));
            run_compute(vb, 40, (r % 3 == 0) ? 3 : 0, $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mac_block_seq.md
Name: mac_block_seq

Overview:
- Sequencer for one MAC block: the per-row multiply-accumulate tile with a local operand memory, a registered multiplier and an accumulator register.
- Runs two command types over a valid/ready input stream:
  - LOAD: writes elementsNum operands into the tile memory.
  - COMPUTE: streams elementsNum operands, driving read address, accumulator clear and accumulator write-enable.
- Tolerates input stalls and flags when the tile's accumulator holds a finished dot product.

Parameters:
- elementsNum, 4, vector length and tile memory depth; must be >= 2.
- dataWidth, 4, operand width of the stream and the tile.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_load  in  1  one-cycle command: begin LOAD (honoured in IDLE only)
- start_compute  in  1  one-cycle command: begin COMPUTE (honoured in IDLE only)
- in_data  in  dataWidth  operand stream data
- in_valid  in  1  operand stream valid
- in_ready  out  1  operand stream ready
- blk_in  out  dataWidth  tile data input; combinational copy of in_data
- blk_we_mem  out  1  tile memory write enable
- blk_wraddr  out  AW  tile memory write address, AW = $clog2(elementsNum)
- blk_rdaddr  out  AW  tile memory read address
- blk_zero_in  out  1  tile accumulator clear-select
- blk_we_out  out  1  tile accumulator write enable
- busy  out  1  high in any state other than IDLE
- load_done  out  1  one-cycle pulse after the final LOAD write
- result_valid  out  1  one-cycle pulse: tile accumulator holds the completed result

Behaviour:
- Tile contract:
  - Tile memory read is combinational on blk_rdaddr.
  - The product of mem[blk_rdaddr] and blk_in is registered in the tile every cycle, unconditionally.
  - The accumulator register loads (blk_zero_in ? 0 : acc) + product on edges where blk_we_out = 1.
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE. Registers: state, cnt[AW-1:0], p_vld, p_first, load_done, result_valid.
- Reset: state = IDLE, cnt = 0, p_vld = 0, p_first = 0, load_done = 0, result_valid = 0. All outputs are 0 except blk_in. A reset mid-operation aborts the operation with no pulse; the tile contents are then don't-care.
- IDLE:
  - in_ready = 0, busy = 0.
  - start_load → LOAD with cnt = 0.
  - Else start_compute → COMPUTE with cnt = 0.
  - If both are high, LOAD wins and start_compute is dropped.
  - Starts in any non-IDLE state are ignored.
- LOAD:
  - in_ready = 1, blk_we_mem = in_valid, blk_wraddr = cnt.
  - Each accepted beat (in_valid & in_ready) increments cnt.
  - Accept with cnt == elementsNum-1 → IDLE, cnt = 0, load_done = 1 next cycle.
- COMPUTE:
  - in_ready = 1, blk_rdaddr = cnt.
  - Accepted beat: cnt++, p_vld <= 1, p_first <= (cnt == 0).
  - Non-accepted cycle: p_vld <= 0, p_first unchanged.
  - Accept with cnt == elementsNum-1 → DRAIN.
- DRAIN:
  - in_ready = 0; p_vld <= 0.
  - Next state DONE; result_valid <= 1.
- DONE: one cycle, then → IDLE. The result stays in the tile until the next COMPUTE.
- Pipeline outputs (all states):
  - blk_we_out = p_vld.
  - blk_zero_in = p_vld & p_first.
  - Stall cycles never write the accumulator; the stale product registered during a stall is discarded.
- Defaults:
  - blk_rdaddr = 0 outside COMPUTE.
  - blk_wraddr = 0 and blk_we_mem = 0 outside LOAD.
- Latency, no stalls: start_compute at cycle 0 → beats accepted cycles 1..N → blk_we_out high cycles 2..N+1 → result_valid high in cycle N+2.
  - Each stall cycle adds 1.
  - LOAD with no stalls: load_done in cycle N+1.
- Width: accumulator needs 2*dataWidth + AW + 1 bits. Overflow is impossible; the worst case is elementsNum*(2^dataWidth-1)^2.

Test Plan:
- Load [1,2,3,4], no stalls (N = 4) → blk_we_mem high cycles 1-4 with blk_wraddr 0,1,2,3; load_done in cycle 5; busy low afterwards.
- After that load, compute with stream [4,3,2,1], no stalls → blk_rdaddr 0..3 in cycles 1-4; blk_zero_in only in cycle 2; blk_we_out cycles 2-5; result_valid in cycle 6; tile out = 20.
- Same compute with in_valid low in cycles 2 and 3 → blk_we_out low in cycles 3 and 4; blk_zero_in still only with the first product; result_valid in cycle 8; out = 20.
- start_load and start_compute high together in IDLE → LOAD entered, no compute; then start_load pulsed mid-COMPUTE → ignored, result unchanged.
- rst asserted in cycle 3 of a COMPUTE → next cycle all outputs 0, state IDLE, no result_valid; a fresh compute then yields a correct result.
- All operands 15 (dataWidth = 4, N = 4) → out = 900, no truncation.
